// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states and the
// instruction field layout used by the decoder.
package pkg_controle;

   localparam logic [4:0] OP_JMP  = 5'h1C;
   localparam logic [4:0] OP_JZ   = 5'h1D;
   localparam logic [4:0] OP_NOP  = 5'h1E;
   localparam logic [4:0] OP_HALT = 5'h1F;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 11;
   localparam int DST_MSB = 10;
   localparam int DST_LSB = 9;
   localparam int SA_MSB  = 8;
   localparam int SA_LSB  = 7;
   localparam int SB_MSB  = 6;
   localparam int SB_LSB  = 5;
   localparam int TGT_MSB = 7;
   localparam int TGT_LSB = 0;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } estado_t;

   typedef struct packed {
      logic       is_alu;
      logic       is_jmp;
      logic       is_jz;
      logic       is_nop;
      logic       is_halt;
      logic [1:0] sel_sa;
      logic [1:0] sel_sb;
      logic [1:0] sel_sc;
      logic [4:0] op;
      logic [7:0] alvo;
   } decod_t;

endpackage

// File: rtl/unidade_controle_if.sv
// Instruction-memory fetch bus: the controller drives address/request,
// memory answers with ack and the instruction word in the same cycle.
interface unidade_controle_if #(
   parameter int bits_palavra = 16,
   parameter int bits_pc      = 8
) ();

   logic [bits_pc-1:0]      mem_addr;
   logic                    mem_req;
   logic                    mem_ack;
   logic [bits_palavra-1:0] mem_data;

   modport master (
      output mem_addr,
      output mem_req,
      input  mem_ack,
      input  mem_data
   );

   modport slave (
      input  mem_addr,
      input  mem_req,
      output mem_ack,
      output mem_data
   );

endinterface

// File: rtl/unidade_controle_decodificador.sv
// Purely combinational instruction decoder: splits the IR into its fields
// and classifies the opcode (ALU range vs. the four control opcodes).
module decodificador
   import pkg_controle::*;
(
   input  logic [15:0] ir_i,
   output decod_t      dec_o
);

   logic [4:0] opc;

   assign opc = ir_i[OPC_MSB:OPC_LSB];

   always_comb begin
      dec_o         = '0;
      dec_o.op      = opc;
      dec_o.sel_sc  = ir_i[DST_MSB:DST_LSB];
      dec_o.sel_sa  = ir_i[SA_MSB:SA_LSB];
      dec_o.sel_sb  = ir_i[SB_MSB:SB_LSB];
      dec_o.alvo    = ir_i[TGT_MSB:TGT_LSB];
      dec_o.is_alu  = (opc < OP_JMP);
      dec_o.is_jmp  = (opc == OP_JMP);
      dec_o.is_jz   = (opc == OP_JZ);
      dec_o.is_nop  = (opc == OP_NOP);
      dec_o.is_halt = (opc == OP_HALT);
   end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetches over the req/ack bus, decodes and drives
// the datapath controls, sequences the PC and stops on HALT.
//
// state  | meaning
// INIT   | one cycle after reset; datapath resets still asserted
// FETCH  | mem_req high at PC, waiting for mem_ack to load IR
// DECODE | IR fields on the datapath; jumps/NOP resolve the PC here
// EXEC   | single write-enable pulse for an ALU op, then PC+1
// HALT   | frozen until reset
module unidade_controle
   import pkg_controle::*;
#(
   parameter int bits_palavra  = 16,
   parameter int end_registros = 2,
   parameter int bits_pc       = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   unidade_controle_if.master       mem,
   input  logic                     flag_Z,
   output logic                     Hab_Escrita,
   output logic [end_registros-1:0] Sel_SA,
   output logic [end_registros-1:0] Sel_SB,
   output logic [end_registros-1:0] Sel_SC,
   output logic [4:0]               controleOperacao,
   output logic                     reset_Ban_Registros,
   output logic                     reset_Flags,
   output logic                     halted,
   output logic [bits_pc-1:0]       pc
);

   estado_t                 estado_q, estado_d;
   logic [bits_pc-1:0]      pc_q, pc_d;
   logic [bits_palavra-1:0] ir_q, ir_d;
   logic [bits_pc-1:0]      pc_mais_um;
   logic                    mem_req_w;
   decod_t                  dec;

   decodificador u_decod (
      .ir_i  (ir_q[15:0]),
      .dec_o (dec)
   );

   assign pc_mais_um   = pc_q + bits_pc'(1);
   assign pc           = reset ? '0 : pc_q;
   assign mem.mem_addr = reset ? '0 : pc_q;
   assign mem.mem_req  = mem_req_w;

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= ST_INIT;
         pc_q     <= '0;
         ir_q     <= '0;
      end else begin
         estado_q <= estado_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
      end
   end

   always_comb begin
      estado_d            = estado_q;
      pc_d                = pc_q;
      ir_d                = ir_q;
      mem_req_w           = 1'b0;
      Hab_Escrita         = 1'b0;
      Sel_SA              = '0;
      Sel_SB              = '0;
      Sel_SC              = '0;
      controleOperacao    = '0;
      reset_Ban_Registros = 1'b0;
      reset_Flags         = 1'b0;
      halted              = 1'b0;

      case (estado_q)
         ST_INIT: begin
            reset_Ban_Registros = 1'b1;
            reset_Flags         = 1'b1;
            estado_d            = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req_w = 1'b1;
            if (mem.mem_ack) begin
               ir_d     = mem.mem_data;
               estado_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            Sel_SA           = end_registros'(dec.sel_sa);
            Sel_SB           = end_registros'(dec.sel_sb);
            Sel_SC           = end_registros'(dec.sel_sc);
            controleOperacao = dec.op;
            if (dec.is_alu) begin
               estado_d = ST_EXEC;
            end else if (dec.is_jmp) begin
               pc_d     = bits_pc'(dec.alvo);
               estado_d = ST_FETCH;
            end else if (dec.is_jz) begin
               // flag_Z already holds the result of the last EXEC
               pc_d     = flag_Z ? bits_pc'(dec.alvo) : pc_mais_um;
               estado_d = ST_FETCH;
            end else if (dec.is_nop) begin
               pc_d     = pc_mais_um;
               estado_d = ST_FETCH;
            end else if (dec.is_halt) begin
               estado_d = ST_HALT;
            end
         end
         ST_EXEC: begin
            Sel_SA           = end_registros'(dec.sel_sa);
            Sel_SB           = end_registros'(dec.sel_sb);
            Sel_SC           = end_registros'(dec.sel_sc);
            controleOperacao = dec.op;
            Hab_Escrita      = 1'b1;
            pc_d             = pc_mais_um;
            estado_d         = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            estado_d = ST_INIT;
         end
      endcase

      // Reset wins immediately so a pending request drops in the reset cycle
      if (reset) begin
         mem_req_w           = 1'b0;
         Hab_Escrita         = 1'b0;
         Sel_SA              = '0;
         Sel_SB              = '0;
         Sel_SC              = '0;
         controleOperacao    = '0;
         halted              = 1'b0;
         reset_Ban_Registros = 1'b1;
         reset_Flags         = 1'b1;
      end
   end

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench: the bench plays instruction memory and flag register,
// and an instruction-level model predicts fetch addresses and write pulses.
module tb_unidade_controle;

   logic       clk = 1'b0;
   logic       reset;
   logic       flag_Z;
   logic       Hab_Escrita;
   logic [1:0] Sel_SA, Sel_SB, Sel_SC;
   logic [4:0] controleOperacao;
   logic       reset_Ban_Registros, reset_Flags, halted;
   logic [7:0] pc;

   int n_checks = 0;
   int n_errors = 0;
   int m_pc     = 0;

   always #5 clk = ~clk;

   unidade_controle_if mem_if ();

   unidade_controle dut (
      .clk                 (clk),
      .reset               (reset),
      .mem                 (mem_if),
      .flag_Z              (flag_Z),
      .Hab_Escrita         (Hab_Escrita),
      .Sel_SA              (Sel_SA),
      .Sel_SB              (Sel_SB),
      .Sel_SC              (Sel_SC),
      .controleOperacao    (controleOperacao),
      .reset_Ban_Registros (reset_Ban_Registros),
      .reset_Flags         (reset_Flags),
      .halted              (halted),
      .pc                  (pc)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_we"}, Hab_Escrita, 0);
      check_val({tag, "_sa"}, Sel_SA, 0);
      check_val({tag, "_sb"}, Sel_SB, 0);
      check_val({tag, "_sc"}, Sel_SC, 0);
      check_val({tag, "_op"}, controleOperacao, 0);
   endtask

   task automatic check_fields(input string tag, input logic [15:0] instr);
      check_val({tag, "_sc"}, Sel_SC, instr[10:9]);
      check_val({tag, "_sa"}, Sel_SA, instr[8:7]);
      check_val({tag, "_sb"}, Sel_SB, instr[6:5]);
      check_val({tag, "_op"}, controleOperacao, instr[15:11]);
   endtask

   task automatic do_reset(input int ncyc);
      reset = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         check_val("rst_ban", reset_Ban_Registros, 1);
         check_val("rst_flg", reset_Flags, 1);
         check_val("rst_req", mem_if.mem_req, 0);
         check_val("rst_halt", halted, 0);
         check_val("rst_pc", pc, 0);
         check_idle("rst");
         mem_if.mem_ack = 1'($urandom);
         step();
      end
      reset = 1'b0;
      mem_if.mem_ack = 1'b0;
      check_val("init_ban", reset_Ban_Registros, 1);
      check_val("init_flg", reset_Flags, 1);
      check_val("init_req", mem_if.mem_req, 0);
      check_idle("init");
      step();
      check_val("post_ban", reset_Ban_Registros, 0);
      check_val("post_flg", reset_Flags, 0);
      m_pc = 0;
   endtask

   // One full instruction: fetch (with wait states), decode, optional exec.
   task automatic run_instr(input logic [15:0] instr, input int n_wait, input logic fz);
      int opc;
      opc = int'(instr[15:11]);
      check_val("f_req", mem_if.mem_req, 1);
      check_val("f_addr", mem_if.mem_addr, m_pc);
      check_val("f_pc", pc, m_pc);
      check_val("f_halt", halted, 0);
      check_idle("f");
      for (int i = 0; i < n_wait; i++) begin
         mem_if.mem_ack  = 1'b0;
         mem_if.mem_data = 16'($urandom);
         flag_Z          = 1'($urandom);
         step();
         check_val("w_req", mem_if.mem_req, 1);
         check_val("w_addr", mem_if.mem_addr, m_pc);
         check_idle("w");
      end
      mem_if.mem_ack  = 1'b1;
      mem_if.mem_data = instr;
      flag_Z          = 1'($urandom);
      step();
      check_val("d_req", mem_if.mem_req, 0);
      check_val("d_we", Hab_Escrita, 0);
      if (opc < 28) check_fields("d", instr);
      mem_if.mem_ack  = 1'($urandom);
      mem_if.mem_data = 16'($urandom);
      flag_Z          = fz;
      step();
      if (opc < 28) begin
         check_val("x_we", Hab_Escrita, 1);
         check_val("x_req", mem_if.mem_req, 0);
         check_fields("x", instr);
         mem_if.mem_ack = 1'($urandom);
         flag_Z         = 1'($urandom);
         step();
         m_pc = (m_pc + 1) % 256;
      end else if (opc == 28) begin
         m_pc = int'(instr[7:0]);
      end else if (opc == 29) begin
         m_pc = fz ? int'(instr[7:0]) : (m_pc + 1) % 256;
      end else if (opc == 30) begin
         m_pc = (m_pc + 1) % 256;
      end
   endtask

   initial begin
      logic [15:0] instr;
      int          r;
      reset           = 1'b1;
      flag_Z          = 1'b0;
      mem_if.mem_ack  = 1'b0;
      mem_if.mem_data = '0;
      #1;
      do_reset(2);

      run_instr(16'h0A40, 3, 1'b0);
      run_instr(16'hE830, 0, 1'b1);
      check_val("jz_taken", mem_if.mem_addr, 8'h30);
      run_instr(16'hE830, 1, 1'b0);
      check_val("jz_not", mem_if.mem_addr, 8'h31);
      run_instr(16'hE0FF, 0, 1'b0);
      run_instr(16'hF000, 0, 1'b0);
      check_val("wrap", mem_if.mem_addr, 8'h00);
      run_instr(16'hE010, 2, 1'b0);
      check_val("jmp", mem_if.mem_addr, 8'h10);

      for (int k = 0; k < 300; k++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)       instr = {5'($urandom_range(0, 27)), 11'($urandom)};
         else if (r == 6) instr = {5'h1C, 11'($urandom)};
         else if (r < 9)  instr = {5'h1D, 11'($urandom)};
         else             instr = {5'h1E, 11'($urandom)};
         run_instr(instr, int'($urandom_range(0, 3)), 1'($urandom));
      end

      // Reset while a request is pending; the ack that follows must be ignored
      check_val("mf_req", mem_if.mem_req, 1);
      reset = 1'b1;
      #1;
      check_val("mf_req_drop", mem_if.mem_req, 0);
      step();
      reset           = 1'b0;
      mem_if.mem_ack  = 1'b1;
      mem_if.mem_data = 16'hE0AA;
      #1;
      check_val("mf_init_req", mem_if.mem_req, 0);
      check_val("mf_init_ban", reset_Ban_Registros, 1);
      step();
      mem_if.mem_ack = 1'b0;
      m_pc = 0;
      run_instr(16'h0A40, 0, 1'b0);

      run_instr(16'hF800, 1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         check_val("h_halt", halted, 1);
         check_val("h_req", mem_if.mem_req, 0);
         check_val("h_pc", pc, m_pc);
         check_idle("h");
         mem_if.mem_ack = 1'($urandom);
         flag_Z         = 1'($urandom);
         step();
      end
      reset = 1'b1;
      #1;
      check_val("h_rst_halt", halted, 0);
      do_reset(1);
      run_instr(16'hF000, 0, 1'b0);
      check_val("h_restart", mem_if.mem_addr, 8'h01);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
